// File: rtl/bat_pkg.sv
// Shared types, screen constants and the length-code to width mapping for the player bat.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bat_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STILL  = 2'd1,
      MOVE_L = 2'd2,
      MOVE_R = 2'd3
   } bat_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 11;
   localparam int SPEED_W  = 6;
   localparam int LEN_W    = 3;

   // Length code 1/2/4 selects half, nominal or double width; any other code
   // falls back to nominal so a glitched code never produces a zero width.
   function automatic logic [COORD_W-1:0] bat_width(input logic [LEN_W-1:0] len,
                                                    input int obj_w);
      int w;
      case (len)
         3'd1:    w = obj_w / 2;
         3'd4:    w = obj_w * 2;
         default: w = obj_w;
      endcase
      return COORD_W'(w);
   endfunction

endpackage

// File: rtl/bat_move_control_if.sv
// Frame-control and position bus between the game logic and the bat mover.
// Latency: none (wiring only).
// Backpressure: none; keys/pulses are levels, position is a registered level.
interface bat_move_control_if;
   import bat_pkg::*;

   logic               startOfFrame;
   logic               leftKey;
   logic               rightKey;
   logic               preStart;
   logic [LEN_W-1:0]   legnth;
   logic [COORD_W-1:0] topLeftX;
   logic [COORD_W-1:0] topLeftY;
   logic               moving;

   // Game side: drives frame pulse, keys and length; observes bat position.
   modport master (
      output startOfFrame, leftKey, rightKey, preStart, legnth,
      input  topLeftX, topLeftY, moving
   );

   // Bat mover side.
   modport slave (
      input  startOfFrame, leftKey, rightKey, preStart, legnth,
      output topLeftX, topLeftY, moving
   );
endinterface

// File: rtl/bat_speed_ramp.sv
// Per-frame speed generator: constant MIN_SPEED, or a held-key ramp when BAT_ACCEL_EN is defined.
// Latency: speed for the current frame is combinational; ramp state updates on the frame tick.
// Backpressure: none; advances only on tick.
module bat_speed_ramp
   import bat_pkg::*;
#(
   parameter int MIN_SPEED    = 2,
   parameter int MAX_SPEED    = 8,
   parameter int ACCEL_FRAMES = 4
)(
   input  logic               clk,
   input  logic               resetN,
   input  logic               tick,     // frame evaluation cycle
   input  logic               hold,     // bat moves this frame
   input  logic               restart,  // this frame starts a new run (or no move)
   output logic [SPEED_W-1:0] speed     // speed applied this frame
);

`ifdef BAT_ACCEL_EN
   localparam logic [SPEED_W-1:0] MIN_S    = SPEED_W'(MIN_SPEED);
   localparam logic [SPEED_W-1:0] MAX_S    = SPEED_W'(MAX_SPEED);
   localparam logic [7:0]         CNT_LAST = 8'(ACCEL_FRAMES - 1);

   logic [SPEED_W-1:0] speed_q, base_spd, spd_d;
   logic [7:0]         cnt_q, base_cnt, cnt_d;

   // A restarting frame always runs at MIN_SPEED and counts as frame one of the run;
   // every ACCEL_FRAMES moved frames bump the speed until the ceiling, then freeze.
   always_comb begin
      base_spd = restart ? MIN_S : speed_q;
      base_cnt = restart ? 8'd0  : cnt_q;
      spd_d    = base_spd;
      cnt_d    = base_cnt;
      if (hold && (base_spd < MAX_S)) begin
         if (base_cnt == CNT_LAST) begin
            cnt_d = 8'd0;
            spd_d = base_spd + SPEED_W'(1);
         end else begin
            cnt_d = base_cnt + 8'd1;
         end
      end
   end

   assign speed = base_spd;

   // Ramp state advances only on frame ticks.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         speed_q <= MIN_S;
         cnt_q   <= 8'd0;
      end else if (tick) begin
         speed_q <= spd_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   localparam int accel_cfg_unused = MAX_SPEED + ACCEL_FRAMES;

   logic ramp_inputs_unused;
   assign ramp_inputs_unused = ^{clk, resetN, tick, hold, restart};

   assign speed = SPEED_W'(MIN_SPEED);
`endif

endmodule

// File: rtl/bat_move_control.sv
// Per-frame bat position controller (keys, optional BAT_ACCEL_EN speed ramp, playfield clamp).
// Latency: outputs registered; update the cycle after the startOfFrame pulse, stable otherwise.
// Backpressure: none; inputs sampled only on startOfFrame, short key presses are dropped.
module bat_move_control
   import bat_pkg::*;
#(
   parameter int INITIAL_X      = 270,
   parameter int INITIAL_Y      = 440,
   parameter int OBJECT_WIDTH_X = 100,
   parameter int LEFT_BOUND     = 0,
   parameter int RIGHT_BOUND    = SCREEN_W,
   parameter int MIN_SPEED      = 2,
   parameter int MAX_SPEED      = 8,
   parameter int ACCEL_FRAMES   = 4
)(
   input  logic              clk,
   input  logic              resetN,
   bat_move_control_if.slave bat
);

   localparam logic [COORD_W-1:0] INIT_X  = COORD_W'(INITIAL_X);
   localparam logic signed [11:0] LO_S    = 12'(LEFT_BOUND);
   localparam logic signed [11:0] RIGHT_S = 12'(RIGHT_BOUND);

   bat_state_t         state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [SPEED_W-1:0] speed;
   logic               want_l, want_r;
   logic               move_frame, new_run;
   logic signed [11:0] hi_s, x_s, spd_s, cand_s;

   // Keep inside [lo, hi]; lo is applied last so it wins if the bat is wider than the field.
   function automatic logic signed [11:0] clamp_x(input logic signed [11:0] v,
                                                  input logic signed [11:0] lo,
                                                  input logic signed [11:0] hi);
      logic signed [11:0] r;
      r = v;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   // Direction decode and ramp control: both-keys counts as no key.
   always_comb begin
      want_l     = bat.leftKey & ~bat.rightKey;
      want_r     = bat.rightKey & ~bat.leftKey;
      move_frame = bat.startOfFrame & ~bat.preStart & (state_q != IDLE) & (want_l | want_r);
      new_run    = (want_l & (state_q != MOVE_L)) | (want_r & (state_q != MOVE_R));
   end

   bat_speed_ramp #(
      .MIN_SPEED    (MIN_SPEED),
      .MAX_SPEED    (MAX_SPEED),
      .ACCEL_FRAMES (ACCEL_FRAMES)
   ) u_ramp (
      .clk     (clk),
      .resetN  (resetN),
      .tick    (bat.startOfFrame),
      .hold    (move_frame),
      .restart (~move_frame | new_run),
      .speed   (speed)
   );

   // Next state and next X, evaluated only in the frame cycle; signed 12-bit math keeps
   // a left step past zero negative so the clamp sees it instead of a wrapped value.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      hi_s    = RIGHT_S - signed'({1'b0, bat_width(bat.legnth, OBJECT_WIDTH_X)});
      x_s     = signed'({1'b0, x_q});
      spd_s   = signed'({{(12 - SPEED_W){1'b0}}, speed});
      cand_s  = x_s;
      if (bat.startOfFrame) begin
         if (bat.preStart) begin
            state_d = IDLE;
            x_d     = INIT_X;
         end else begin
            if (state_q == IDLE) begin
               state_d = STILL;
            end else if (want_l) begin
               state_d = MOVE_L;
               cand_s  = x_s - spd_s;
            end else if (want_r) begin
               state_d = MOVE_R;
               cand_s  = x_s + spd_s;
            end else begin
               state_d = STILL;
            end
            x_d = COORD_W'(clamp_x(cand_s, LO_S, hi_s));
         end
      end
   end

   // State and position registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         x_q     <= INIT_X;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
      end
   end

   assign bat.topLeftX = x_q;
   assign bat.topLeftY = COORD_W'(INITIAL_Y);
   assign bat.moving   = (state_q == MOVE_L) || (state_q == MOVE_R);

endmodule
